// File: rtl/blit_dma_if.sv
// Job-control, ROM/RAM and VRAM signal bundle for the blit/DMA engine.
// master = engine side, slave = CPU / memory side.
interface blit_dma_if #(
  parameter int unsigned ADDR_W = 12,
  parameter int unsigned DATA_W = 8,
  parameter int unsigned BPP    = 2,
  parameter int unsigned H_BITS = 7,
  parameter int unsigned V_BITS = 6
);
  logic              start;
  logic              mode;
  logic [ADDR_W-1:0] src_addr;
  logic [ADDR_W-1:0] dst_addr;
  logic [ADDR_W-1:0] length;
  logic              busy;
  logic              done;
  logic [ADDR_W-1:0] rom_addr;
  logic [DATA_W-1:0] rom_dout;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_din;
  logic [DATA_W-1:0] ram_dout;
  logic              ram_we;
  logic [H_BITS-1:0] vram_hpos;
  logic [V_BITS-1:0] vram_vpos;
  logic [BPP-1:0]    vram_pixeli;
  logic [BPP-1:0]    vram_pixelo;
  logic              vram_we;
  logic              collision;

  modport master (
    input  start, mode, src_addr, dst_addr, length, rom_dout, ram_dout, vram_pixelo,
    output busy, done, rom_addr, ram_addr, ram_din, ram_we,
           vram_hpos, vram_vpos, vram_pixeli, vram_we, collision
  );

  modport slave (
    output start, mode, src_addr, dst_addr, length, rom_dout, ram_dout, vram_pixelo,
    input  busy, done, rom_addr, ram_addr, ram_din, ram_we,
           vram_hpos, vram_vpos, vram_pixeli, vram_we, collision
  );
endinterface

// File: rtl/blit_dma_engine.sv
// ROM->RAM block copy and packed-pixel RAM->VRAM frame draw engine.
// Optional BLIT_XOR_EN: XOR pixel drawing with sticky collision detection.
module blit_dma_engine #(
  parameter int unsigned ADDR_W = 12,
  parameter int unsigned DATA_W = 8,
  parameter int unsigned BPP    = 2,
  parameter int unsigned H_BITS = 7,
  parameter int unsigned V_BITS = 6
) (
  input logic        clk,
  input logic        rst_n,
  blit_dma_if.master bus
);
  localparam int unsigned PPB   = DATA_W / BPP;
  localparam int unsigned SUB_W = (PPB > 1) ? $clog2(PPB) : 1;
  localparam int unsigned PIX_W = H_BITS + V_BITS;
  localparam logic [SUB_W-1:0] SUB_LAST = SUB_W'(PPB - 1);
  localparam logic [PIX_W-1:0] PIX_LAST = '1;

  typedef enum logic [2:0] {
    IDLE, COPY_PRIME, COPY_RUN, DRAW_FETCH, DRAW_PIXEL, FINISH
  } state_t;

  state_t            state_q, state_n;
  logic [ADDR_W-1:0] src_q, src_n;
  logic [ADDR_W-1:0] dst_q, dst_n;
  logic [ADDR_W-1:0] cnt_q, cnt_n;
  logic [PIX_W-1:0]  pix_q, pix_n;
  logic [SUB_W-1:0]  sub_q, sub_n;
  logic [ADDR_W-1:0] rom_addr_q, rom_addr_n;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_n;
  logic              ram_we_q, ram_we_n;
  logic              vram_we_q, vram_we_n;
  logic              busy_q, busy_n;
  logic              done_q, done_n;
  logic              coll_q, coll_n;

  logic [BPP-1:0]    pix_new_c;
  logic [BPP-1:0]    pix_out_c;
  logic              hit_c;

  // Pixel sub_q of the current byte, MSB-first
  assign pix_new_c = BPP'(bus.ram_dout >> ((PPB - 1 - 32'(sub_q)) * BPP));

`ifdef BLIT_XOR_EN
  assign pix_out_c = pix_new_c ^ bus.vram_pixelo;
  assign hit_c     = |(pix_new_c & bus.vram_pixelo);
`else
  logic unused_pixelo_c;
  assign unused_pixelo_c = ^bus.vram_pixelo;
  assign pix_out_c       = pix_new_c;
  assign hit_c           = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      src_q      <= '0;
      dst_q      <= '0;
      cnt_q      <= '0;
      pix_q      <= '0;
      sub_q      <= '0;
      rom_addr_q <= '0;
      ram_addr_q <= '0;
      ram_we_q   <= 1'b0;
      vram_we_q  <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      coll_q     <= 1'b0;
    end else begin
      state_q    <= state_n;
      src_q      <= src_n;
      dst_q      <= dst_n;
      cnt_q      <= cnt_n;
      pix_q      <= pix_n;
      sub_q      <= sub_n;
      rom_addr_q <= rom_addr_n;
      ram_addr_q <= ram_addr_n;
      ram_we_q   <= ram_we_n;
      vram_we_q  <= vram_we_n;
      busy_q     <= busy_n;
      done_q     <= done_n;
      coll_q     <= coll_n;
    end
  end

  // Next state plus next values of every registered output
  always_comb begin
    state_n    = state_q;
    src_n      = src_q;
    dst_n      = dst_q;
    cnt_n      = cnt_q;
    pix_n      = pix_q;
    sub_n      = sub_q;
    rom_addr_n = rom_addr_q;
    ram_addr_n = ram_addr_q;
    ram_we_n   = 1'b0;
    vram_we_n  = 1'b0;
    busy_n     = busy_q;
    done_n     = 1'b0;
    coll_n     = coll_q;

    case (state_q)
      IDLE: begin
        busy_n = 1'b0;
        if (bus.start) begin
          busy_n = 1'b1;
          coll_n = 1'b0;
          cnt_n  = bus.length;
          dst_n  = bus.dst_addr;
          src_n  = bus.src_addr;
          if (bus.mode) begin
            state_n    = DRAW_FETCH;
            ram_addr_n = bus.src_addr;
            pix_n      = '0;
            sub_n      = '0;
          end else begin
            state_n    = COPY_PRIME;
            rom_addr_n = bus.src_addr;
          end
        end
      end
      // ROM output of the previous cycle is written while the next byte is read
      COPY_PRIME, COPY_RUN: begin
        if (cnt_q == '0) begin
          state_n = FINISH;
          done_n  = 1'b1;
        end else begin
          state_n    = COPY_RUN;
          ram_we_n   = 1'b1;
          ram_addr_n = dst_q;
          dst_n      = dst_q + ADDR_W'(1);
          src_n      = src_q + ADDR_W'(1);
          rom_addr_n = src_q + ADDR_W'(1);
          cnt_n      = cnt_q - ADDR_W'(1);
        end
      end
      DRAW_FETCH: begin
        state_n   = DRAW_PIXEL;
        vram_we_n = 1'b1;
      end
      DRAW_PIXEL: begin
        if (hit_c) coll_n = 1'b1;
        if (sub_q == SUB_LAST) begin
          sub_n = '0;
          if (pix_q == PIX_LAST) begin
            state_n = FINISH;
            done_n  = 1'b1;
          end else begin
            state_n    = DRAW_FETCH;
            ram_addr_n = ram_addr_q + ADDR_W'(1);
            pix_n      = pix_q + PIX_W'(1);
          end
        end else begin
          sub_n     = sub_q + SUB_W'(1);
          pix_n     = pix_q + PIX_W'(1);
          vram_we_n = 1'b1;
        end
      end
      FINISH: begin
        state_n = IDLE;
        busy_n  = 1'b0;
      end
      default: state_n = IDLE;
    endcase
  end

  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.rom_addr    = rom_addr_q;
  assign bus.ram_addr    = ram_addr_q;
  assign bus.ram_we      = ram_we_q;
  assign bus.ram_din     = bus.rom_dout;
  assign bus.vram_hpos   = pix_q[H_BITS-1:0];
  assign bus.vram_vpos   = pix_q[PIX_W-1:H_BITS];
  assign bus.vram_pixeli = pix_out_c;
  assign bus.vram_we     = vram_we_q;
  assign bus.collision   = coll_q;
endmodule

// File: tb/tb_blit_dma_engine.sv
// Scoreboard bench for blit_dma_engine: copy, wrap, ignored start, back-to-back,
// full-frame draw, XOR collision (with BLIT_XOR_EN) and reset mid-draw.
`timescale 1ns/1ps
module tb_blit_dma_engine;
  localparam int unsigned ADDR_W = 12;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned BPP    = 2;
  localparam int unsigned H_BITS = 7;
  localparam int unsigned V_BITS = 6;
  localparam int unsigned NPIX   = 1 << (H_BITS + V_BITS);
  localparam int unsigned PPB    = DATA_W / BPP;

  typedef struct packed {
    logic [12:0] addr;
    logic [7:0]  data;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  int         vectors = 0;
  int         miscompares = 0;
  logic       bd_fill = 1'b0;
  logic [7:0] fill_b0 = 8'h00;
  logic [1:0] fill_v0 = 2'd0;
  logic [7:0] ram  [4096];
  logic [1:0] vram [8192];
  exp_t       sb[$];

  blit_dma_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .BPP(BPP), .H_BITS(H_BITS), .V_BITS(V_BITS)) bus ();

  blit_dma_engine #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .BPP(BPP), .H_BITS(H_BITS), .V_BITS(V_BITS)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] rom_fn(input logic [11:0] a);
    case (a)
      12'h010: return 8'hA1;
      12'h011: return 8'hB2;
      12'h012: return 8'hC3;
      12'h013: return 8'hD4;
      default: return a[7:0] ^ 8'h5A;
    endcase
  endfunction

  function automatic logic [7:0] ram_fill(input int i);
    return (i == 0) ? fill_b0 : 8'(i * 7 + 3);
  endfunction

  function automatic logic [1:0] vram_fill(input int i);
    return (i == 0) ? fill_v0 : 2'(i * 5);
  endfunction

  // Sync ROM/RAM, combinational-read VRAM, plus a one-cycle backdoor fill
  always @(posedge clk) begin
    bus.rom_dout <= rom_fn(bus.rom_addr);
    bus.ram_dout <= ram[bus.ram_addr];
    if (bd_fill) begin
      for (int i = 0; i < 4096; i++) ram[i] <= ram_fill(i);
      for (int i = 0; i < 8192; i++) vram[i] <= vram_fill(i);
    end else begin
      if (bus.ram_we) ram[bus.ram_addr] <= bus.ram_din;
      if (bus.vram_we) vram[{bus.vram_vpos, bus.vram_hpos}] <= bus.vram_pixeli;
    end
  end

  assign bus.vram_pixelo = vram[{bus.vram_vpos, bus.vram_hpos}];

  task automatic test_reset();
    vectors++; if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
    vectors++; if (bus.done !== 1'b0) begin miscompares++; $display("FAIL reset_done: got %b want 0", bus.done); end
    vectors++; if (bus.ram_we !== 1'b0) begin miscompares++; $display("FAIL reset_ram_we: got %b want 0", bus.ram_we); end
    vectors++; if (bus.vram_we !== 1'b0) begin miscompares++; $display("FAIL reset_vram_we: got %b want 0", bus.vram_we); end
    vectors++; if (bus.collision !== 1'b0) begin miscompares++; $display("FAIL reset_collision: got %b want 0", bus.collision); end
    vectors++; if (bus.rom_addr !== 12'h000) begin miscompares++; $display("FAIL reset_rom_addr: got %h want 000", bus.rom_addr); end
    vectors++; if (bus.ram_addr !== 12'h000) begin miscompares++; $display("FAIL reset_ram_addr: got %h want 000", bus.ram_addr); end
    vectors++; if (bus.vram_hpos !== 7'd0) begin miscompares++; $display("FAIL reset_hpos: got %0d want 0", bus.vram_hpos); end
    vectors++; if (bus.vram_vpos !== 6'd0) begin miscompares++; $display("FAIL reset_vpos: got %0d want 0", bus.vram_vpos); end
  endtask

  // Caller is at a negedge; start goes high now, returns at the negedge after done
  task automatic run_copy(input string nm, input logic [11:0] src, input logic [11:0] dst,
                          input logic [11:0] len, input bit intr);
    exp_t e;
    int   t, we_n, busy_n;
    bit   got_done, vwe_seen;
    for (int i = 0; i < int'(len); i++) begin
      e.addr = 13'(12'(dst + 12'(i)));
      e.data = rom_fn(12'(src + 12'(i)));
      sb.push_back(e);
    end
    bus.start = 1'b1; bus.mode = 1'b0;
    bus.src_addr = src; bus.dst_addr = dst; bus.length = len;
    t = 0; we_n = 0; busy_n = 0; got_done = 0; vwe_seen = 0;
    while (!got_done && t < int'(len) + 20) begin
      @(negedge clk); t++;
      if (t == 1) begin
        bus.start = 1'b0;
        vectors++; if (bus.collision !== 1'b0) begin miscompares++; $display("FAIL %s collision_clear: got %b want 0", nm, bus.collision); end
      end
      if (intr && t == 2) begin
        bus.start = 1'b1; bus.mode = 1'b1;
        bus.src_addr = 12'h100; bus.dst_addr = 12'h500; bus.length = 12'd9;
      end
      if (intr && t == 4) begin bus.start = 1'b0; bus.mode = 1'b0; end
      if (bus.busy) busy_n++;
      if (bus.vram_we) vwe_seen = 1;
      if (bus.ram_we) begin
        we_n++;
        vectors++;
        if (sb.size() == 0) begin
          miscompares++; $display("FAIL %s extra_write: got addr %h data %h want none", nm, bus.ram_addr, bus.ram_din);
        end else begin
          e = sb.pop_front();
          if ({1'b0, bus.ram_addr} !== e.addr || bus.ram_din !== e.data) begin
            miscompares++; $display("FAIL %s ram_write: got %h:%h want %h:%h", nm, bus.ram_addr, bus.ram_din, e.addr[11:0], e.data);
          end
        end
      end
      if (bus.done) got_done = 1;
    end
    vectors++; if (!got_done) begin miscompares++; $display("FAIL %s done_timeout: got no done want done at %0d", nm, int'(len) + 2); end
    vectors++; if (t != int'(len) + 2) begin miscompares++; $display("FAIL %s done_cycle: got %0d want %0d", nm, t, int'(len) + 2); end
    vectors++; if (we_n != int'(len)) begin miscompares++; $display("FAIL %s ram_we_count: got %0d want %0d", nm, we_n, int'(len)); end
    vectors++; if (busy_n != int'(len) + 2) begin miscompares++; $display("FAIL %s busy_cycles: got %0d want %0d", nm, busy_n, int'(len) + 2); end
    vectors++; if (vwe_seen) begin miscompares++; $display("FAIL %s vram_we_in_copy: got 1 want 0", nm); end
    vectors++; if (sb.size() != 0) begin miscompares++; $display("FAIL %s missing_writes: got %0d left want 0", nm, sb.size()); sb.delete(); end
    @(negedge clk);
    vectors++; if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin miscompares++; $display("FAIL %s idle_after: got busy %b done %b want 0 0", nm, bus.busy, bus.done); end
    for (int i = 0; i < int'(len); i++) begin
      vectors++;
      if (ram[12'(dst + 12'(i))] !== rom_fn(12'(src + 12'(i)))) begin
        miscompares++; $display("FAIL %s ram_content[%h]: got %h want %h", nm, 12'(dst + 12'(i)), ram[12'(dst + 12'(i))], rom_fn(12'(src + 12'(i))));
      end
    end
  endtask

  task automatic run_draw(input string nm, input logic [7:0] b0, input logic [1:0] v0,
                          input logic [7:0] first4_exp);
    exp_t       e;
    logic [7:0] by;
    logic [1:0] nw, old;
    logic [7:0] first4;
    bit         coll_exp, got_done, rwe_seen;
    int         t, vwe_n;
    fill_b0 = b0; fill_v0 = v0;
    bd_fill = 1'b1; @(negedge clk); bd_fill = 1'b0;
    coll_exp = 0;
    for (int p = 0; p < int'(NPIX); p++) begin
      by  = ram_fill(p / int'(PPB));
      nw  = 2'(by >> (6 - 2 * (p % int'(PPB))));
      old = vram_fill(p);
      e.addr = 13'(p);
`ifdef BLIT_XOR_EN
      e.data = {6'b0, nw ^ old};
      if ((nw & old) != 2'b00) coll_exp = 1;
`else
      e.data = {6'b0, nw};
`endif
      sb.push_back(e);
    end
    bus.start = 1'b1; bus.mode = 1'b1;
    bus.src_addr = 12'h000; bus.dst_addr = 12'hABC; bus.length = 12'h007;
    t = 0; vwe_n = 0; got_done = 0; rwe_seen = 0; first4 = 8'h00;
    while (!got_done && t < 10300) begin
      @(negedge clk); t++;
      if (t == 1) begin bus.start = 1'b0; bus.mode = 1'b0; end
      if (bus.ram_we) rwe_seen = 1;
      if (bus.vram_we) begin
        if (vwe_n < 4) first4[2*vwe_n +: 2] = bus.vram_pixeli;
        vwe_n++;
        vectors++;
        if (sb.size() == 0) begin
          miscompares++; $display("FAIL %s extra_pixel: got (%0d,%0d) want none", nm, bus.vram_hpos, bus.vram_vpos);
        end else begin
          e = sb.pop_front();
          if ({bus.vram_vpos, bus.vram_hpos} !== e.addr || {6'b0, bus.vram_pixeli} !== e.data) begin
            miscompares++; $display("FAIL %s pixel: got %0d=%0d want %0d=%0d", nm, {bus.vram_vpos, bus.vram_hpos}, bus.vram_pixeli, e.addr, e.data[1:0]);
          end
        end
      end
      if (bus.done) got_done = 1;
    end
    vectors++; if (!got_done) begin miscompares++; $display("FAIL %s done_timeout: got no done want done at 10241", nm); end
    vectors++; if (t != 10241) begin miscompares++; $display("FAIL %s done_cycle: got %0d want 10241", nm, t); end
    vectors++; if (vwe_n != int'(NPIX)) begin miscompares++; $display("FAIL %s vram_we_count: got %0d want %0d", nm, vwe_n, NPIX); end
    vectors++; if (rwe_seen) begin miscompares++; $display("FAIL %s ram_we_in_draw: got 1 want 0", nm); end
    vectors++; if (first4 !== first4_exp) begin miscompares++; $display("FAIL %s first_pixels: got %h want %h", nm, first4, first4_exp); end
    vectors++; if (sb.size() != 0) begin miscompares++; $display("FAIL %s missing_pixels: got %0d left want 0", nm, sb.size()); sb.delete(); end
    @(negedge clk);
    vectors++; if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL %s idle_after: got busy %b want 0", nm, bus.busy); end
    vectors++; if (bus.collision !== coll_exp) begin miscompares++; $display("FAIL %s collision: got %b want %b", nm, bus.collision, coll_exp); end
  endtask

  task automatic test_copy_basic();  run_copy("copy_basic", 12'h010, 12'h200, 12'd4, 1'b0); endtask
  task automatic test_copy_zero();   run_copy("copy_zero",  12'h010, 12'h300, 12'd0, 1'b0); endtask
  task automatic test_copy_wrap();   run_copy("copy_wrap",  12'hFFE, 12'hFFF, 12'd3, 1'b0); endtask
  task automatic test_start_ignored(); run_copy("start_ignored", 12'h020, 12'h300, 12'd5, 1'b1); endtask

  task automatic test_back_to_back();
    run_copy("b2b_a", 12'h040, 12'h600, 12'd2, 1'b0);
    run_copy("b2b_b", 12'h080, 12'h700, 12'd3, 1'b0);
  endtask

  task automatic test_draw();
`ifdef BLIT_XOR_EN
    run_draw("draw", 8'h1B, 2'd0, 8'h00);
`else
    run_draw("draw", 8'h1B, 2'd0, 8'hE4);
`endif
  endtask

`ifdef BLIT_XOR_EN
  task automatic test_xor_collision();
    run_draw("xor", 8'hC0, 2'd3, 8'hE4);
    vectors++; if (vram[0] !== 2'd0) begin miscompares++; $display("FAIL xor_pixel00: got %0d want 0", vram[0]); end
    run_copy("xor_clear", 12'h010, 12'h400, 12'd0, 1'b0);
  endtask
`endif

  task automatic test_reset_mid_draw();
    int t;
    bit seen_we, bad;
    bus.start = 1'b1; bus.mode = 1'b1; bus.src_addr = 12'h000;
    t = 0; seen_we = 0;
    while (!seen_we && t < 200) begin
      @(negedge clk); t++;
      if (t == 1) begin bus.start = 1'b0; bus.mode = 1'b0; end
      if (t > 50 && bus.vram_we) seen_we = 1;
    end
    vectors++; if (!seen_we) begin miscompares++; $display("FAIL rst_mid_draw_setup: got no vram_we want vram_we"); end
    rst_n = 1'b0;
    #1;
    vectors++; if (bus.vram_we !== 1'b0) begin miscompares++; $display("FAIL rst_mid_draw_vram_we: got %b want 0", bus.vram_we); end
    vectors++; if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL rst_mid_draw_busy: got %b want 0", bus.busy); end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    bad = 0;
    repeat (30) begin
      @(negedge clk);
      if (bus.done || bus.busy || bus.vram_we || bus.ram_we) bad = 1;
    end
    vectors++; if (bad) begin miscompares++; $display("FAIL rst_mid_draw_quiet: got activity after reset want none"); end
  endtask

  initial begin
    bus.start = 1'b0; bus.mode = 1'b0;
    bus.src_addr = '0; bus.dst_addr = '0; bus.length = '0;
    repeat (3) @(negedge clk);
    test_reset();
    rst_n = 1'b1;
    @(negedge clk);
    test_copy_basic();
    test_copy_zero();
    test_copy_wrap();
    test_start_ignored();
    test_back_to_back();
    test_draw();
`ifdef BLIT_XOR_EN
    test_xor_collision();
`endif
    test_reset_mid_draw();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/blit_dma_engine.md
Name: blit_dma_engine

Overview:
Parametrised memory-transfer and framebuffer-draw engine that replaces the fixed boot copy and fixed full-screen draw sequence in the CPU.
- COPY mode moves a programmable-length block from ROM to RAM.
- DRAW mode unpacks packed-pixel RAM bytes into the VRAM raster.
- The CPU controller starts a job with a start/busy/done handshake, then hands control back when the job ends.

Parameters:
ADDR_W, 12, ROM/RAM address width and length width
DATA_W, 8, ROM/RAM data width
BPP, 2, bits per pixel; must divide DATA_W; PPB = DATA_W/BPP pixels per byte
H_BITS, 7, VRAM horizontal position width (screen width 2^H_BITS)
V_BITS, 6, VRAM vertical position width (screen height 2^V_BITS)

Ports:
clk  in  1  clock; all logic on rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  job request; sampled only in IDLE
mode  in  1  0=COPY, 1=DRAW; sampled with start
src_addr  in  ADDR_W  COPY: ROM source; DRAW: RAM source of first pixel byte
dst_addr  in  ADDR_W  COPY: RAM destination; ignored in DRAW
length  in  ADDR_W  COPY byte count; ignored in DRAW
busy  out  1  job in progress
done  out  1  one-cycle pulse at job end
rom_addr  out  ADDR_W  ROM address (sync ROM, 1-cycle read latency)
rom_dout  in  DATA_W  ROM data
ram_addr  out  ADDR_W  RAM address (sync RAM, 1-cycle read latency)
ram_din  out  DATA_W  RAM write data
ram_dout  in  DATA_W  RAM read data
ram_we  out  1  RAM write strobe
vram_hpos  out  H_BITS  pixel x
vram_vpos  out  V_BITS  pixel y
vram_pixeli  out  BPP  pixel write value
vram_pixelo  in  BPP  pixel read value; combinational from current hpos/vpos
vram_we  out  1  VRAM write strobe
collision  out  1  sticky XOR-collision flag (0 unless BLIT_XOR_EN)

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE.
  - busy, done, ram_we, vram_we, collision = 0.
  - All address and position outputs = 0.
  - Reset mid-job aborts immediately; no further write strobes are issued.
- States: IDLE, COPY_PRIME, COPY_RUN, DRAW_FETCH, DRAW_PIXEL, FINISH.
- IDLE:
  - start=1 latches mode/src/dst/length.
  - Next state: COPY_PRIME if mode=0; DRAW_FETCH if mode=1.
  - busy rises on the next cycle.
  - start while busy is ignored; parameters are not re-latched.
- COPY_PRIME:
  - rom_addr=src.
  - length=0 → FINISH with no ram_we.
  - Otherwise → COPY_RUN.
- COPY_RUN, each cycle:
  - ram_we=1, ram_din=rom_dout, ram_addr=dst.
  - rom_addr advances to src+1 so data streams at 1 byte/cycle.
  - src, dst and the remaining count update each cycle.
  - After the length-th write → FINISH.
  - Addresses wrap modulo 2^ADDR_W.
  - Total job = length+2 cycles from start to done.
- DRAW:
  - A linear pixel counter P runs 0..2^(H_BITS+V_BITS)-1.
  - hpos=P[H_BITS-1:0], vpos=P[H_BITS+V_BITS-1:H_BITS].
  - Byte address = src + P/PPB, wrapping.
- DRAW_FETCH: drive ram_addr, no write, → DRAW_PIXEL.
- DRAW_PIXEL:
  - ram_addr is held constant.
  - PPB consecutive cycles, each with vram_we=1.
  - Pixel k of the byte (k=0..PPB-1) = ram_dout[DATA_W-1-k*BPP -: BPP], MSB-first.
  - After the last pixel of a byte: P=max → FINISH, else → DRAW_FETCH.
  - Full frame = (2^(H_BITS+V_BITS)/PPB)*(PPB+1) cycles; defaults: 2048 bytes, 10240 cycles.
- FINISH:
  - done=1 and busy=1 for exactly one cycle, then IDLE with busy=0.
  - start may be accepted on the cycle after done.
- ram_we and vram_we are never asserted in the same cycle.

Optional Feature:
BLIT_XOR_EN
- Defined:
  - DRAW writes vram_pixeli = new ^ vram_pixelo.
  - collision is set when any pixel has (new & vram_pixelo) != 0, i.e. a lit pixel is turned off.
  - collision is sticky and is cleared when a new job is accepted.
  - Cycle timing is unchanged, since vram_pixelo is combinational.
- Undefined: DRAW overwrites (vram_pixeli = new) and collision is tied 0.

Test Plan:
- COPY src=0x010, dst=0x200, length=4, ROM[0x10..0x13]=A1,B2,C3,D4 → RAM[0x200..0x203]=A1,B2,C3,D4; ram_we high exactly 4 cycles; done pulses 6 cycles after start.
- COPY length=0 → no ram_we; done pulses 2 cycles after start; busy high 2 cycles total.
- COPY src=0xFFE, dst=0xFFF, length=3 → RAM[0xFFF], RAM[0x000], RAM[0x001] receive ROM[0xFFE], ROM[0xFFF], ROM[0x000] (address wrap).
- DRAW src=0, RAM[0]=0x1B, defaults → pixels (0,0)..(3,0) written 0,1,2,3; 8192 vram_we pulses; done after 10240+1 cycles.
- start asserted again mid-COPY with different params → ignored, original transfer completes; rst_n low mid-DRAW → vram_we=0 immediately, busy=0, no done pulse.
- BLIT_XOR_EN: VRAM(0,0)=3, RAM[0]=0xC0, DRAW → (0,0) written 0, collision=1; next job start → collision clears to 0.
